lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store initiator that sits between the pipeline MEM stage and the RAM data port (mem_read, mem_write, data_addr, write_data, store_type, load_type, read_data).
- Accepts one request at a time over a valid/ready handshake.
- An access contained in one aligned 8-byte dword is issued as a single RAM access.
- An access crossing a dword boundary is split into two aligned dword accesses: reassembled and extended for loads, read-modify-write for stores.
- Returns a one-cycle response pulse.

Parameters:
- ADDR_W, 64, request and RAM address width.
- DATA_W, 64, data width. Only 64 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword.
- req_unsigned  in  1  zero-extend the load result; ignored for stores.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, LSB-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  extended load data; 0 for stores.
- mem_read  out  1  RAM read enable.
- mem_write  out  1  RAM write enable.
- data_addr  out  ADDR_W  RAM address.
- write_data  out  DATA_W  RAM write data.
- load_type  out  3  0 none, 1 LB, 2 LH, 3 LW, 4 LD, 5 LBU, 6 LHU, 7 LWU.
- store_type  out  3  0 none, 1 SB, 2 SH, 3 SW, 4 SD.
- read_data  in  DATA_W  RAM read data; combinational, valid in the same cycle as mem_read.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high (rst).
- Reset values:
  - State IDLE, req_ready=1, resp_valid=0, resp_rdata=0.
  - mem_read=0, mem_write=0, load_type=0, store_type=0, data_addr=0, write_data=0.
  - All internal capture registers 0.
- Acceptance and capture:
  - A request is accepted on a clock edge with req_valid & req_ready.
  - we, size, unsigned, addr and wdata are captured. Inputs are ignored outside IDLE.
- Offsets and split rule:
  - off = addr[2:0]; nbytes = 1 << size.
  - split = (off + nbytes) > 8, evaluated in 4-bit arithmetic.
  - alo = {addr[ADDR_W-1:3], 3'b000}; ahi = alo + 8, wrapping modulo 2^ADDR_W.
- State machine (one state per cycle unless noted):
  - IDLE:
    - accept and not split -> ACC.
    - accept, split, load -> RLO.
    - accept, split, store -> RLO, then RHI, WLO, WHI.
  - ACC:
    - Drive data_addr = addr.
    - Load: mem_read=1, load_type from size/unsigned; RAM handles offset and extension; capture read_data.
    - Store: mem_write=1, store_type from size, write_data = wdata.
    - Next state RESP.
  - RLO: data_addr=alo, mem_read=1, load_type=LD; capture read_data into lo. Next RHI.
  - RHI: data_addr=ahi, mem_read=1, load_type=LD; capture read_data into hi.
    - Load -> RESP.
    - Store -> WLO.
  - WLO: data_addr=alo, mem_write=1, store_type=SD.
    - write_data = lo with bytes off..7 replaced by wdata bytes 0..(7-off).
    - Next WHI.
  - WHI: data_addr=ahi, mem_write=1, store_type=SD.
    - write_data = hi with bytes 0..(off+nbytes-9) replaced by the remaining wdata bytes.
    - Next RESP.
  - RESP: resp_valid=1 for exactly one cycle; req_ready=0. Next IDLE.
    - Split-load resp_rdata: ({hi,lo} >> (8*off)) truncated to nbytes, then sign- or zero-extended per unsigned (size 11 is never extended).
- Latency, from accept edge T:
  - Unsplit access: resp_valid in cycle T+2.
  - Split load: resp_valid in cycle T+3.
  - Split store: resp_valid in cycle T+5.
  - Next accept is possible in the cycle after RESP.
- Drive discipline: mem_read and mem_write are never both high. load_type and store_type are 0 whenever the matching enable is low.
- Split stores are not atomic. A reset between WLO and WHI leaves the low dword written and the high dword unwritten; this is accepted.
- Reset mid-operation: next state is IDLE; no further RAM enables; resp_valid is not emitted for the aborted request.
- Top of address space: ahi wraps to 0 when alo = 2^ADDR_W-8.

Test Plan:
- Aligned LD at 0x1000, RAM dword = 0x1122334455667788 -> one mem_read, load_type=4; resp_rdata = 0x1122334455667788 at T+2.
- LW at 0x1006: dword@0x1000 = 0xBBAA000000000000, dword@0x1008 = 0x00000000000000DDCC.
  - Required: RLO/RHI reads at 0x1000 then 0x1008.
  - Required: resp_rdata = 0xFFFFFFFFDDCCBBAA at T+3.
  - Same access as LWU -> 0x00000000DDCCBBAA.
- SD 0x0807060504030201 at 0x2003, both dwords initially 0xFF..FF:
  - Reads at 0x2000 and 0x2008.
  - Writes 0x0504030201FFFFFF to 0x2000 and 0xFFFFFFFFFF080706 to 0x2008.
  - resp_valid at T+5.
- SH at 0x3001 (no split) -> single mem_write, store_type=2, data_addr=0x3001; resp at T+2.
- rst asserted during RHI of a split store -> IDLE next cycle; no mem_write observed; resp_valid stays 0; req_ready=1.
- req_valid held high continuously -> accepts only in IDLE; a second request's fields changing mid-operation do not affect the in-flight request.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response handshake plus RAM data port of the load/store unit
interface lsu_ctrl_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] write_data;
    logic [2:0]        load_type;
    logic [2:0]        store_type;
    logic [DATA_W-1:0] read_data;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, read_data,
        input  req_ready, resp_valid, resp_rdata, mem_read, mem_write, data_addr,
               write_data, load_type, store_type
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, read_data,
        output req_ready, resp_valid, resp_rdata, mem_read, mem_write, data_addr,
               write_data, load_type, store_type
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator; dword-crossing accesses become two aligned dword accesses
module lsu_ctrl #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input logic       clk,
    input logic       rst,
    lsu_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ACC, RLO, RHI, WLO, WHI, RESP} state_t;

    state_t            state, nxt;
    logic              we, uns;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr, alo, ahi;
    logic [DATA_W-1:0] wdata, lo, hi, mlo, mhi, cat, ext;
    logic [5:0]        sh;
    logic [3:0]        nb;
    logic [2:0]        k, lt_acc;
    logic              split, split_in, accept;

    assign accept   = bus.req_valid & bus.req_ready;
    assign split_in = ({1'b0, bus.req_addr[2:0]} + (4'd1 << bus.req_size)) > 4'd8;
    assign nb       = 4'd1 << size;
    assign split    = ({1'b0, addr[2:0]} + nb) > 4'd8;
    assign sh       = {addr[2:0], 3'b000};
    // bytes spilling into the high dword: off + nbytes - 8, taken modulo 8
    assign k        = addr[2:0] + nb[2:0];
    assign alo      = {addr[ADDR_W-1:3], 3'b000};
    assign ahi      = alo + ADDR_W'(8);
    assign mlo      = {DATA_W{1'b1}} << sh;
    assign mhi      = ~({DATA_W{1'b1}} << {k, 3'b000});
    assign cat      = DATA_W'({hi, lo} >> sh);
    assign lt_acc   = size == 2'd3 ? 3'd4 : {uns, size} + 3'd1;
    assign ext      = size == 2'd0 ? {{(DATA_W-8){~uns & cat[7]}}, cat[7:0]} :
                      size == 2'd1 ? {{(DATA_W-16){~uns & cat[15]}}, cat[15:0]} :
                      size == 2'd2 ? {{(DATA_W-32){~uns & cat[31]}}, cat[31:0]} : cat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            we    <= 1'b0;
            uns   <= 1'b0;
            size  <= 2'd0;
            addr  <= '0;
            wdata <= '0;
            lo    <= '0;
            hi    <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                we    <= bus.req_we;
                uns   <= bus.req_unsigned;
                size  <= bus.req_size;
                addr  <= bus.req_addr;
                wdata <= bus.req_wdata;
            end
            if ((state == ACC && !we) || state == RLO) lo <= bus.read_data;
            if (state == RHI) hi <= bus.read_data;
        end
    end

    always_comb begin
        nxt            = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.data_addr  = '0;
        bus.write_data = '0;
        bus.load_type  = 3'd0;
        bus.store_type = 3'd0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) nxt = split_in ? RLO : ACC;
            end
            ACC: begin
                bus.data_addr  = addr;
                bus.mem_read   = !we;
                bus.mem_write  = we;
                bus.load_type  = we ? 3'd0 : lt_acc;
                bus.store_type = we ? {1'b0, size} + 3'd1 : 3'd0;
                bus.write_data = we ? wdata : '0;
                nxt            = RESP;
            end
            RLO: begin
                bus.data_addr = alo;
                bus.mem_read  = 1'b1;
                bus.load_type = 3'd4;
                nxt           = RHI;
            end
            RHI: begin
                bus.data_addr = ahi;
                bus.mem_read  = 1'b1;
                bus.load_type = 3'd4;
                nxt           = we ? WLO : RESP;
            end
            WLO: begin
                bus.data_addr  = alo;
                bus.mem_write  = 1'b1;
                bus.store_type = 3'd4;
                bus.write_data = (lo & ~mlo) | ((wdata << sh) & mlo);
                nxt            = WHI;
            end
            WHI: begin
                bus.data_addr  = ahi;
                bus.mem_write  = 1'b1;
                bus.store_type = 3'd4;
                bus.write_data = (hi & ~mhi) | ((wdata >> (7'd64 - 7'(sh))) & mhi);
                nxt            = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = we ? '0 : split ? ext : lo;
                nxt            = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and random requests against a byte-level memory reference model
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_ctrl_if #(.ADDR_W(64), .DATA_W(64)) bus();
    lsu_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
    } req_t;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [2:0]  typ;
        logic [63:0] data;
    } ev_t;

    ev_t         log_q[$];
    logic [7:0]  ram  [logic [63:0]];
    logic [7:0]  gold [logic [63:0]];
    int          n_assert = 0;
    int          n_fail = 0;
    logic        wr_pend = 1'b0;
    logic [63:0] wr_addr, wr_data;
    logic [2:0]  wr_type;

    function automatic logic [7:0] init_b(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_b(input logic [63:0] a);
        return ram.exists(a) ? ram[a] : init_b(a);
    endfunction

    function automatic logic [7:0] gold_b(input logic [63:0] a);
        return gold.exists(a) ? gold[a] : init_b(a);
    endfunction

    function automatic logic [63:0] dw_ram(input logic [63:0] a);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = ram_b(a + 64'(i));
        return v;
    endfunction

    function automatic logic [63:0] dw_gold(input logic [63:0] a);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = gold_b(a + 64'(i));
        return v;
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] v, input int nb, input logic sgn);
        logic [63:0] m;
        if (nb >= 8) return v;
        m = (64'd1 << (8*nb)) - 64'd1;
        v = v & m;
        if (sgn && v[8*nb-1]) v = v | ~m;
        return v;
    endfunction

    function automatic int type_bytes(input logic [2:0] t, input logic is_store);
        if (is_store) return t == 3'd1 ? 1 : t == 3'd2 ? 2 : t == 3'd3 ? 4 : t == 3'd4 ? 8 : 0;
        case (t)
            3'd1, 3'd5: return 1;
            3'd2, 3'd6: return 2;
            3'd3, 3'd7: return 4;
            3'd4:       return 8;
            default:    return 0;
        endcase
    endfunction

    // RAM: loads return the addressed bytes already extended according to load_type
    function automatic logic [63:0] ram_rd(input logic [63:0] a, input logic [2:0] lt);
        logic [63:0] v = 64'd0;
        int nb = type_bytes(lt, 1'b0);
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ram_b(a + 64'(i));
        return extend(v, nb, lt inside {3'd1, 3'd2, 3'd3});
    endfunction

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (wr_pend)
            for (int i = 0; i < type_bytes(wr_type, 1'b1); i++) ram[wr_addr + 64'(i)] = wr_data[8*i +: 8];
        #1;
        cmp("rd_wr_excl", 64'(bus.mem_read & bus.mem_write), 64'd0);
        cmp("lt_zero", 64'(bus.mem_read ? 3'd0 : bus.load_type), 64'd0);
        cmp("st_zero", 64'(bus.mem_write ? 3'd0 : bus.store_type), 64'd0);
        if (bus.mem_read || bus.mem_write)
            log_q.push_back('{bus.mem_write, bus.data_addr,
                              bus.mem_write ? bus.store_type : bus.load_type, bus.write_data});
        wr_pend = bus.mem_write;
        wr_addr = bus.data_addr;
        wr_data = bus.write_data;
        wr_type = bus.store_type;
        bus.read_data = bus.mem_read ? ram_rd(bus.data_addr, bus.load_type) : 64'd0;
    endtask

    task automatic preload(input logic [63:0] a, input logic [63:0] d);
        for (int i = 0; i < 8; i++) begin
            ram[a + 64'(i)]  = d[8*i +: 8];
            gold[a + 64'(i)] = d[8*i +: 8];
        end
    endtask

    task automatic drive(input req_t r);
        bus.req_we       = r.we;
        bus.req_size     = r.size;
        bus.req_unsigned = r.uns;
        bus.req_addr     = r.addr;
        bus.req_wdata    = r.wdata;
    endtask

    task automatic scramble();
        bus.req_we       = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = {$urandom, $urandom};
        bus.req_wdata    = {$urandom, $urandom};
    endtask

    task automatic do_req(input req_t r, input bit hold, input req_t nr, output logic [63:0] rd);
        int          nb = 1 << r.size;
        int          off = int'(r.addr[2:0]);
        bit          split = (off + nb) > 8;
        logic [63:0] alo = r.addr & ~64'h7;
        logic [63:0] ahi = alo + 64'd8;
        logic [63:0] v = 64'd0;
        logic [63:0] exp_rd = 64'd0;
        logic [2:0]  t;
        int          exp_lat = !split ? 2 : r.we ? 5 : 3;
        int          lat, guard;
        ev_t         ex[$];
        if (!r.we) begin
            for (int i = 0; i < nb; i++) v[8*i +: 8] = gold_b(r.addr + 64'(i));
            exp_rd = extend(v, nb, !r.uns);
        end
        if (!split) begin
            t = r.we ? 3'(nb == 1 ? 1 : nb == 2 ? 2 : nb == 4 ? 3 : 4)
                     : 3'(nb == 8 ? 4 : (nb == 1 ? 1 : nb == 2 ? 2 : 3) + (r.uns ? 4 : 0));
            ex.push_back('{r.we, r.addr, t, 64'd0});
        end else begin
            ex.push_back('{1'b0, alo, 3'd4, 64'd0});
            ex.push_back('{1'b0, ahi, 3'd4, 64'd0});
            if (r.we) begin
                ex.push_back('{1'b1, alo, 3'd4, 64'd0});
                ex.push_back('{1'b1, ahi, 3'd4, 64'd0});
            end
        end
        if (r.we) for (int i = 0; i < nb; i++) gold[r.addr + 64'(i)] = r.wdata[8*i +: 8];
        drive(r);
        bus.req_valid = 1'b1;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            tick();
            guard++;
        end
        cmp("accept_ready", 64'(bus.req_ready), 64'd1);
        log_q.delete();
        tick();
        if (hold) scramble();
        else bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 12) begin
            tick();
            lat++;
            if (hold) scramble();
        end
        cmp("latency", 64'(lat), 64'(exp_lat));
        rd = bus.resp_rdata;
        cmp("resp_rdata", rd, exp_rdata_fix(exp_rd, r.we));
        if (hold) drive(nr);
        tick();
        cmp("resp_pulse", 64'(bus.resp_valid), 64'd0);
        cmp("ready_after", 64'(bus.req_ready), 64'd1);
        cmp("n_events", 64'(log_q.size()), 64'(ex.size()));
        for (int i = 0; i < ex.size() && i < log_q.size(); i++) begin
            cmp("ev_kind", 64'(log_q[i].wr), 64'(ex[i].wr));
            cmp("ev_addr", log_q[i].addr, ex[i].addr);
            cmp("ev_type", 64'(log_q[i].typ), 64'(ex[i].typ));
        end
        cmp("ram_lo", dw_ram(alo), dw_gold(alo));
        cmp("ram_hi", dw_ram(ahi), dw_gold(ahi));
    endtask

    function automatic logic [63:0] exp_rdata_fix(input logic [63:0] v, input logic we);
        return we ? 64'd0 : v;
    endfunction

    initial begin
        req_t        r, b;
        logic [63:0] rd;
        int          nwr;
        bus.req_valid = 1'b0;
        bus.read_data = 64'd0;
        drive('{1'b0, 2'd0, 1'b0, 64'd0, 64'd0});
        tick();
        tick();
        cmp("rst_ready", 64'(bus.req_ready), 64'd1);
        cmp("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        cmp("rst_resp_rdata", bus.resp_rdata, 64'd0);
        cmp("rst_mem_read", 64'(bus.mem_read), 64'd0);
        cmp("rst_mem_write", 64'(bus.mem_write), 64'd0);
        cmp("rst_types", 64'({bus.load_type, bus.store_type}), 64'd0);
        cmp("rst_data_addr", bus.data_addr, 64'd0);
        cmp("rst_write_data", bus.write_data, 64'd0);
        rst = 1'b0;
        tick();

        preload(64'h1000, 64'h1122334455667788);
        r = '{1'b0, 2'd3, 1'b0, 64'h1000, 64'd0};
        do_req(r, 1'b0, r, rd);
        cmp("ld_aligned", rd, 64'h1122334455667788);

        preload(64'h1000, 64'hBBAA000000000000);
        preload(64'h1008, 64'h00000000000000DD_CC >> 0);
        preload(64'h1008, 64'h000000000000DDCC);
        r = '{1'b0, 2'd2, 1'b0, 64'h1006, 64'd0};
        do_req(r, 1'b0, r, rd);
        cmp("lw_split", rd, 64'hFFFFFFFFDDCCBBAA);
        r.uns = 1'b1;
        do_req(r, 1'b0, r, rd);
        cmp("lwu_split", rd, 64'h00000000DDCCBBAA);

        preload(64'h2000, '1);
        preload(64'h2008, '1);
        r = '{1'b1, 2'd3, 1'b0, 64'h2003, 64'h0807060504030201};
        do_req(r, 1'b0, r, rd);
        cmp("sd_wlo_data", log_q[2].data, 64'h0504030201FFFFFF);
        cmp("sd_whi_data", log_q[3].data, 64'hFFFFFFFFFF080706);
        cmp("sd_ram_lo", dw_ram(64'h2000), 64'h0504030201FFFFFF);
        cmp("sd_ram_hi", dw_ram(64'h2008), 64'hFFFFFFFFFF080706);

        r = '{1'b1, 2'd1, 1'b0, 64'h3001, 64'h123456789ABCBEEF};
        do_req(r, 1'b0, r, rd);
        cmp("sh_addr", log_q[0].addr, 64'h3001);

        preload(64'hFFFFFFFFFFFFFFF8, 64'h8899AABBCCDDEEFF);
        preload(64'h0, 64'h0706050403020100);
        r = '{1'b0, 2'd1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'd0};
        do_req(r, 1'b0, r, rd);
        cmp("top_wrap", rd, 64'h0000000000000088);

        // reset during RHI of a split store must abort before any write
        r = '{1'b1, 2'd2, 1'b0, 64'h5005, 64'hCAFEF00D};
        drive(r);
        bus.req_valid = 1'b1;
        log_q.delete();
        tick();
        bus.req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("abort_write", 64'(bus.mem_write), 64'd0);
        cmp("abort_read", 64'(bus.mem_read), 64'd0);
        cmp("abort_ready", 64'(bus.req_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            cmp("abort_resp", 64'(bus.resp_valid), 64'd0);
            tick();
        end
        nwr = 0;
        foreach (log_q[i]) if (log_q[i].wr) nwr++;
        cmp("abort_nwr", 64'(nwr), 64'd0);
        cmp("abort_ram_lo", dw_ram(64'h5000), dw_gold(64'h5000));
        cmp("abort_ram_hi", dw_ram(64'h5008), dw_gold(64'h5008));

        r = '{1'b0, 2'd2, 1'b0, 64'h6006, 64'd0};
        b = '{1'b1, 2'd3, 1'b0, 64'h6013, 64'h0123456789ABCDEF};
        do_req(r, 1'b1, b, rd);
        do_req(b, 1'b0, b, rd);
        r = '{1'b0, 2'd3, 1'b0, 64'h6010, 64'd0};
        do_req(r, 1'b0, r, rd);

        for (int n = 0; n < 80; n++) begin
            r.we    = 1'($urandom);
            r.size  = 2'($urandom);
            r.uns   = 1'($urandom);
            r.wdata = {$urandom, $urandom};
            r.addr  = ($urandom_range(0, 7) == 0) ? 64'hFFFFFFFFFFFFFFF8 + 64'($urandom_range(0, 7))
                                                   : 64'h4000 + 64'($urandom_range(0, 47));
            do_req(r, 1'b0, r, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
